// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA/SVGA raster timing generator. A clock divider produces a
// pixel tick; on each tick the x/y raster position advances and the sync,
// active-video and strobe outputs are registered from the *next* position so
// that every output describes the same pixel as x/y.
//
// Optional build macro: VGA_LINE_MATCH_EN adds line_cmp / line_match.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run enable; 0 freezes divider, position and level outputs
//   pix_tick     high in the clk cycle before each position update
//   x, y         current pixel column / line
//   hsync/vsync  sync outputs at parameter polarity
//   activevideo  1 inside the visible area
//   line_start   one-clk pulse after x is loaded with 0
//   frame_start  one-clk pulse after (x,y) is loaded with (0,0)
//   line_cmp     compare line                     (VGA_LINE_MATCH_EN)
//   line_match   one-clk pulse on line_cmp start  (VGA_LINE_MATCH_EN)
module vga_timing_gen #(
    parameter int XBITS       = 10,
    parameter int YBITS       = 10,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int H_SYNC_HIGH = 0,
    parameter int V_SYNC_HIGH = 0,
    parameter int CLK_DIV     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef VGA_LINE_MATCH_EN
    input  logic [YBITS-1:0] line_cmp,
    output logic             line_match,
`endif
    output logic             pix_tick,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             activevideo,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [XBITS-1:0] H_LAST   = XBITS'(H_TOTAL - 1);
    localparam logic [YBITS-1:0] V_LAST   = YBITS'(V_TOTAL - 1);
    localparam logic [XBITS-1:0] H_VIS    = XBITS'(H_VISIBLE);
    localparam logic [YBITS-1:0] V_VIS    = YBITS'(V_VISIBLE);
    localparam logic [XBITS-1:0] HS_BEG   = XBITS'(H_VISIBLE + H_FP);
    localparam logic [XBITS-1:0] HS_END   = XBITS'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [YBITS-1:0] VS_BEG   = YBITS'(V_VISIBLE + V_FP);
    localparam logic [YBITS-1:0] VS_END   = YBITS'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic             H_ON     = (H_SYNC_HIGH != 0);
    localparam logic             V_ON     = (V_SYNC_HIGH != 0);

    logic [DIV_W-1:0] r_div;
    logic [XBITS-1:0] r_x;
    logic [YBITS-1:0] r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_x_wrap;
    logic [XBITS-1:0] w_x_next;
    logic [YBITS-1:0] w_y_next;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_active_next;

    // With CLK_DIV=1 DIV_LAST is 0 and r_div never leaves 0, so the tick is en.
    assign w_tick = en && (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    assign w_x_wrap = (r_x == H_LAST);
    assign w_x_next = w_x_wrap ? '0 : r_x + XBITS'(1);
    assign w_y_next = !w_x_wrap ? r_y :
                      ((r_y == V_LAST) ? '0 : r_y + YBITS'(1));

    // Level outputs are decoded from the position being loaded, not the
    // current one, so they change on the same edge as x/y.
    assign w_hs_on       = (w_x_next >= HS_BEG) && (w_x_next <= HS_END);
    assign w_vs_on       = (w_y_next >= VS_BEG) && (w_y_next <= VS_END);
    assign w_active_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_hsync  <= ~H_ON;
            r_vsync  <= ~V_ON;
            r_active <= 1'b0;
        end else if (w_tick) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_hsync  <= w_hs_on ? H_ON : ~H_ON;
            r_vsync  <= w_vs_on ? V_ON : ~V_ON;
            r_active <= w_active_next;
        end
    end

    // Strobes are recomputed every clk so they last exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick && w_x_wrap;
            r_frame_start <= w_tick && w_x_wrap && (r_y == V_LAST);
        end
    end

`ifdef VGA_LINE_MATCH_EN
    logic r_line_match;

    // y_next never exceeds V_TOTAL-1, so out-of-range compare values never hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_match <= 1'b0;
        end else begin
            r_line_match <= w_tick && w_x_wrap && (w_y_next == line_cmp);
        end
    end

    assign line_match = r_line_match;
`endif

    assign pix_tick    = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign activevideo = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int XB  = 5;
    localparam int YB  = 4;
    localparam int HV  = 20;
    localparam int HFP = 3;
    localparam int HS  = 4;
    localparam int HBP = 5;
    localparam int VV  = 6;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HSH = 0;
    localparam int VSH = 1;
    localparam int D   = 3;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FRAME_CLK = HT * VT * D;
    localparam int VW  = XB + YB + 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic pix_tick;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic hsync, vsync, activevideo, line_start, frame_start;
`ifdef VGA_LINE_MATCH_EN
    logic [YB-1:0] line_cmp = '0;
    logic line_match;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: count of pixel ticks and of enabled clocks since reset.
    int m_n = 0;
    int m_e = 0;
    bit m_ticked = 0;
    bit m_last = 0;
    bit m_lm = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .XBITS(XB), .YBITS(YB),
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_SYNC_HIGH(HSH), .V_SYNC_HIGH(VSH), .CLK_DIV(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
`ifdef VGA_LINE_MATCH_EN
        .line_cmp(line_cmp),
        .line_match(line_match),
`endif
        .pix_tick(pix_tick),
        .x(x),
        .y(y),
        .hsync(hsync),
        .vsync(vsync),
        .activevideo(activevideo),
        .line_start(line_start),
        .frame_start(frame_start)
    );

    logic [VW-1:0] obs;
    assign obs = {pix_tick, x, y, hsync, vsync, activevideo, line_start, frame_start};

    function automatic logic [VW-1:0] expv();
        int px, py;
        logic t, hs, vs, av, ls, fs;
        px = m_n % HT;
        py = (m_n / HT) % VT;
        t  = en && ((m_e % D) == D - 1);
        hs = (px >= HV + HFP && px <= HV + HFP + HS - 1) ? (HSH != 0) : (HSH == 0);
        vs = (py >= VV + VFP && py <= VV + VFP + VS - 1) ? (VSH != 0) : (VSH == 0);
        av = m_ticked && px < HV && py < VV;
        ls = m_last && px == 0;
        fs = m_last && px == 0 && py == 0;
        return {t, XB'(px), YB'(py), hs, vs, av, ls, fs};
    endfunction

    function automatic int mx();
        return m_n % HT;
    endfunction

    function automatic int my();
        return (m_n / HT) % VT;
    endfunction

    task automatic model_reset();
        m_n = 0; m_e = 0; m_ticked = 0; m_last = 0; m_lm = 0;
    endtask

    // Advance one clk: update the model with the inputs seen at the edge,
    // then return on the falling edge where outputs are sampled.
    task automatic clock_edge();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_last = en && ((m_e % D) == D - 1);
`ifdef VGA_LINE_MATCH_EN
            m_lm = m_last && ((m_n + 1) % HT == 0) &&
                   ((((m_n + 1) / HT) % VT) == int'(line_cmp));
`endif
            if (en) m_e++;
            if (m_last) begin
                m_n++;
                m_ticked = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        en = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (obs !== {1'b0, XB'(0), YB'(0), HSH == 0, VSH == 0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs,
                     {1'b0, XB'(0), YB'(0), HSH == 0, VSH == 0, 1'b0, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            clock_edge();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", i, obs, expv());
            end
        end
        checks++;
        if (x !== XB'(1) || y !== YB'(0) || activevideo !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: got x=%0d y=%0d av=%b expected x=1 y=0 av=1",
                     x, y, activevideo);
        end
    endtask

    task automatic test_frames();
        int fs_cyc[$];
        int hs_cnt, vs_cnt;
        hs_cnt = 0; vs_cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLK + 20; i++) begin
            clock_edge();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL frames cyc %0d: got %h expected %h", i, obs, expv());
            end
            if (frame_start === 1'b1) fs_cyc.push_back(i);
            if (fs_cyc.size() == 1) begin
                if (hsync === (HSH != 0)) hs_cnt++;
                if (vsync === (VSH != 0)) vs_cnt++;
            end
        end
        checks++;
        if (fs_cyc.size() < 2 || fs_cyc[1] - fs_cyc[0] != FRAME_CLK) begin
            errors++;
            $display("FAIL frame_period: got %0d pulses spacing %0d expected spacing %0d",
                     fs_cyc.size(), (fs_cyc.size() < 2) ? -1 : fs_cyc[1] - fs_cyc[0], FRAME_CLK);
        end
        checks++;
        if (hs_cnt != HS * D * VT) begin
            errors++;
            $display("FAIL hsync_width: got %0d clk expected %0d", hs_cnt, HS * D * VT);
        end
        checks++;
        if (vs_cnt != VS * HT * D) begin
            errors++;
            $display("FAIL vsync_width: got %0d clk expected %0d", vs_cnt, VS * HT * D);
        end
    endtask

    task automatic test_en_hold();
        int k, held, waitc;
        bit seen;
        en = 1'b1;
        k = 0;
        while (!(mx() == 10 && my() == 1 && m_last) && k < 3 * FRAME_CLK) begin
            clock_edge();
            k++;
        end
        checks++;
        if (k >= 3 * FRAME_CLK) begin
            errors++;
            $display("FAIL en_hold_reach: got timeout expected x=10 y=1");
        end
        waitc = $urandom_range(0, D - 1);
        for (int i = 0; i < waitc; i++) clock_edge();
        en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            clock_edge();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL en_hold cyc %0d: got %h expected %h", i, obs, expv());
            end
        end
        checks++;
        if (x !== XB'(10) || y !== YB'(1) || line_start !== 1'b0 || pix_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_hold_state: got x=%0d y=%0d ls=%b tick=%b expected x=10 y=1 ls=0 tick=0",
                     x, y, line_start, pix_tick);
        end
        held = waitc;
        en = 1'b1;
        k = 0;
        seen = 0;
        while (!seen && k < 4 * D) begin
            clock_edge();
            k++;
            if (x === XB'(11)) seen = 1;
        end
        checks++;
        if (!seen || k != D - held) begin
            errors++;
            $display("FAIL en_resume: got %0d clk expected %0d", k, D - held);
        end
    endtask

    task automatic test_random_en();
`ifdef VGA_LINE_MATCH_EN
        line_cmp = YB'($urandom_range(0, VT - 1));
`endif
        for (int i = 0; i < 2500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            clock_edge();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random_en cyc %0d: got %h expected %h", i, obs, expv());
            end
`ifdef VGA_LINE_MATCH_EN
            checks++;
            if (line_match !== m_lm) begin
                errors++;
                $display("FAIL random_line_match cyc %0d: got %b expected %b", i, line_match, m_lm);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        int k;
        en = 1'b1;
        k = 0;
        while (!(mx() == HV + HFP + 1 && my() == VV + VFP + 1) && k < 2 * FRAME_CLK) begin
            clock_edge();
            k++;
        end
        checks++;
        if (hsync !== (HSH != 0) || vsync !== (VSH != 0)) begin
            errors++;
            $display("FAIL pre_reset_sync: got hs=%b vs=%b expected both asserted", hsync, vsync);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== {1'b0, XB'(0), YB'(0), HSH == 0, VSH == 0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", obs,
                     {1'b0, XB'(0), YB'(0), HSH == 0, VSH == 0, 1'b0, 1'b0, 1'b0});
        end
        clock_edge();
        clock_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 5 * D; i++) begin
            clock_edge();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL mid_reset_restart cyc %0d: got %h expected %h", i, obs, expv());
            end
        end
        checks++;
        if (x !== XB'(5) || y !== YB'(0)) begin
            errors++;
            $display("FAIL restart_pos: got x=%0d y=%0d expected x=5 y=0", x, y);
        end
    endtask

`ifdef VGA_LINE_MATCH_EN
    task automatic test_line_match();
        int hits, bad;
        en = 1'b1;
        line_cmp = YB'(VV - 1);
        hits = 0; bad = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            clock_edge();
            if (line_match === 1'b1) begin
                hits++;
                if (x !== XB'(0) || y !== YB'(VV - 1)) bad++;
            end
        end
        checks++;
        if (hits != 1 || bad != 0) begin
            errors++;
            $display("FAIL line_match_in_range: got %0d pulses %0d misplaced expected 1 pulse 0 misplaced",
                     hits, bad);
        end
        line_cmp = YB'(VT + 1);
        hits = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            clock_edge();
            if (line_match === 1'b1) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL line_match_out_of_range: got %0d pulses expected 0", hits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_en_hold();
        test_random_en();
        test_mid_reset();
`ifdef VGA_LINE_MATCH_EN
        test_line_match();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator; successor to the fixed 640x480 timer.
- Divides the system clock down to a pixel tick.
- Produces x/y position, sync, active-video, and line/frame strobes for pixel renderers (e.g. sprite/asteroid drawers) and RGB output logic.
- All timing, clock division and sync polarity are set by parameters. Every output is registered and coincident with the x/y it describes.

Parameters:
XBITS, 10, width of x counter; must hold H_TOTAL-1
YBITS, 10, width of y counter; must hold V_TOTAL-1
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_HIGH, 0, 1 = hsync asserted high, 0 = asserted low
V_SYNC_HIGH, 0, 1 = vsync asserted high, 0 = asserted low
CLK_DIV, 4, clk cycles per pixel (>=1)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 freezes divider, counters and outputs
pix_tick  out  1  high in the clk cycle before each position update
x  out  XBITS  current pixel column
y  out  YBITS  current line
hsync  out  1  horizontal sync at parameter polarity
vsync  out  1  vertical sync at parameter polarity
activevideo  out  1  1 when x<H_VISIBLE and y<V_VISIBLE
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
line_cmp  in  YBITS  compare line (VGA_LINE_MATCH_EN only)
line_match  out  1  one-clk pulse (VGA_LINE_MATCH_EN only)

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider:
  - div register counts 0..CLK_DIV-1 and wraps.
  - pix_tick = en && div==CLK_DIV-1, decoded from registers only.
  - CLK_DIV=1: pix_tick = en.
- Position update, on the clk edge where pix_tick=1:
  - x <= x+1, wrapping to 0 after H_TOTAL-1.
  - On x wrap, y <= y+1, wrapping to 0 after V_TOTAL-1.
  - Counters never exceed TOTAL-1.
- Decoded outputs:
  - hsync, vsync, activevideo are decoded from the next position and registered on the same edge as x/y, so they never lag x/y.
  - hsync asserted for x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]; vsync for y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1].
  - Asserted level = H_SYNC_HIGH / V_SYNC_HIGH; otherwise the inverse.
- Strobes: line_start and frame_start are high for exactly one clk, the cycle after the edge that loads x=0 (resp. x=0,y=0). Otherwise 0.
- en=0: divider, x, y and level outputs hold; pulses are 0. Resuming continues from the held state, with no extra tick.
- Reset (any time, including mid-frame), asynchronous:
  - div=0, x=0, y=0, activevideo=0, line_start=0, frame_start=0, line_match=0.
  - hsync and vsync at deasserted level.
- After reset: first pix_tick occurs CLK_DIV clk after rst_n release (en=1). That edge moves to (1,0) with activevideo=1. No frame_start is issued for the reset position; the first frame_start follows the first full wrap.

Optional Feature:
- Macro VGA_LINE_MATCH_EN.
- Defined: line_cmp input and line_match output exist. line_match pulses for one clk when a position update loads x=0 with y==line_cmp. line_cmp is sampled on that edge; out-of-range values never match. Reset value 0.
- Undefined: both ports are absent and no compare logic is built.

Test Plan:
- Defaults, en=1, reset released -> x=1,y=0,activevideo=1 four clk later; frame_start every 1,680,000 clk (800x525x4).
- Defaults -> hsync low exactly for x=656..751 (384 clk/line); vsync low for y=490..491; activevideo 0 for x>=640 or y>=480.
- H_SYNC_HIGH=1, V_SYNC_HIGH=1, CLK_DIV=1 -> hsync high for x=656..751; x advances every clk; line_start every 800 clk.
- en dropped at x=100,y=5 for 37 clk -> x,y,sync hold; no pulses; x=101 appears CLK_DIV-div_held clk after en returns.
- rst_n asserted at x=700,y=491 -> outputs immediately at reset values (hsync/vsync deasserted); restart from (0,0).
- VGA_LINE_MATCH_EN, line_cmp=479 -> one line_match pulse per frame, coincident with x=0,y=479; line_cmp=600 -> never.
